l2_pair_serializer: RTL and testbench

Egress stage for the L=2 reduced-complexity parallel FIR. It accepts the two-lane output pair (lane 1 = y(2k), lane 2 = y(2k+1)) with a valid/ready handshake and buffers up to DEPTH pairs. It emits the samples as one serial stream in time order, y(2k) then y(2k+1). Each sample is rounded and saturated from the wide accumulator width down to the output sample width. The block sits between the parallel filter outputs and the single-rate downstream consumer.

---
 rtl/l2_pair_serializer.sv | 147 ++++++++++++++
 tb/tb_l2_pair_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_pair_serializer.sv
// l2_pair_serializer
// Egress stage for the L=2 parallel FIR. It buffers (y(2k), y(2k+1)) pairs
// and emits them as one time-ordered serial stream. Each sample is rounded
// half-up and saturated from the accumulator width to the output width.
// Storage is a holding register that is walked lane 1 -> lane 2, backed by
// a FIFO of DEPTH-1 pairs.

module l2_pair_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 31,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [IN_WIDTH-1:0]    in_data_1,
  input  logic signed [IN_WIDTH-1:0]    in_data_2,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_phase,
  output logic                          out_sat,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W      = $clog2(DEPTH + 1);
  localparam int FIFO_DEPTH = DEPTH - 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Half an output LSB, and the output range sign-extended to the quantizer width.
  localparam logic signed [IN_WIDTH:0] ROUND_BIAS = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Holding register: empty, presenting lane 1, or presenting lane 2.
  typedef enum logic [1:0] {
    HOLD_EMPTY = 2'd0,
    HOLD_LANE1 = 2'd1,
    HOLD_LANE2 = 2'd2
  } hold_state_t;

  hold_state_t hold_state, hold_state_next;

  logic signed [IN_WIDTH-1:0] hold_lane1, hold_lane2;
  logic [2*IN_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;

  logic accept, pair_done, hold_free, fifo_empty;
  logic fifo_rd, fifo_wr, bypass, load_hold;

  logic signed [IN_WIDTH-1:0] lane_sel;
  logic signed [IN_WIDTH:0]   rounded, quant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake and routing decisions. in_ready comes from registered occupancy only.
  assign in_ready   = occupancy < OCC_FULL;
  assign accept     = in_valid && in_ready;
  assign out_valid  = hold_state != HOLD_EMPTY;
  assign out_phase  = hold_state == HOLD_LANE2;
  assign pair_done  = (hold_state == HOLD_LANE2) && out_ready;
  assign hold_free  = (hold_state == HOLD_EMPTY) || pair_done;
  assign fifo_empty = occupancy == OCC_W'(out_valid);
  assign fifo_rd    = hold_free && !fifo_empty;
  assign bypass     = hold_free && fifo_empty && accept;
  assign load_hold  = fifo_rd || bypass;
  assign fifo_wr    = accept && !bypass;

  // Holding register state: advance lane on each beat, reload or empty after lane 2.
  always_comb begin
    // NOTE: default first so every path assigns the next state; no latch is inferred.
    hold_state_next = hold_state;
    unique case (hold_state)
      HOLD_EMPTY: if (load_hold) hold_state_next = HOLD_LANE1;
      HOLD_LANE1: if (out_ready) hold_state_next = HOLD_LANE2;
      HOLD_LANE2: if (out_ready) hold_state_next = load_hold ? HOLD_LANE1 : HOLD_EMPTY;
      default:    hold_state_next = HOLD_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (reset) hold_state <= HOLD_EMPTY;
    else       hold_state <= hold_state_next;
  end

  // Holding register lanes: load from the FIFO head, or straight from the input on bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_lane1 <= '0;
      hold_lane2 <= '0;
    end else if (load_hold) begin
      if (fifo_rd) {hold_lane2, hold_lane1} <= fifo_mem[rd_ptr];
      else         {hold_lane2, hold_lane1} <= {in_data_2, in_data_1};
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage array is not reset; the pointers and occupancy define what is valid.
    if (fifo_wr) fifo_mem[wr_ptr] <= {in_data_2, in_data_1};
  end

  // FIFO pointers and pair occupancy (FIFO plus holding register).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pair_done})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Quantizer: round half-up, arithmetic shift, saturate to the output range.
  always_comb begin
    lane_sel = out_phase ? hold_lane2 : hold_lane1;
    rounded  = {lane_sel[IN_WIDTH-1], lane_sel} + ROUND_BIAS;
    quant    = rounded >>> SHIFT;
    out_data = quant[OUT_WIDTH-1:0];
    out_sat  = 1'b0;
    if (quant > SAT_MAX) begin
      out_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      out_sat  = 1'b1;
    end else if (quant < SAT_MIN) begin
      out_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      out_sat  = 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_pair_serializer.sv
// tb_l2_pair_serializer
// Directed and random stimulus for l2_pair_serializer. Expected beats are queued
// when a pair is driven and compared when the DUT completes each output beat.

module tb_l2_pair_serializer;

  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = 31;
  localparam int DEPTH     = 4;

  localparam logic signed [63:0] ONE31 = 64'sd1 <<< 31;
  localparam logic signed [63:0] ONE30 = 64'sd1 <<< 30;

  typedef struct packed {
    logic signed [15:0] data;
    logic               phase;
    logic               sat;
  } beat_t;

  logic                        clk;
  logic                        reset;
  logic signed [IN_WIDTH-1:0]  in_data_1, in_data_2;
  logic                        in_valid, in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid, out_ready;
  logic                        out_phase, out_sat;
  logic [$clog2(DEPTH+1)-1:0]  occupancy;

  logic  ready_cmd, rand_en, rand_bit;
  beat_t exp_q[$];
  beat_t mon_exp;
  int    occ_model;
  int    n_checks, n_pass;

  l2_pair_serializer #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data_1(in_data_1),
    .in_data_2(in_data_2),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_phase(out_phase),
    .out_sat  (out_sat),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random downstream readiness, about 70% high, refreshed each cycle.
  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 99) < 70);
  end

  assign out_ready = rand_en ? rand_bit : ready_cmd;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic beat_t mk(input int d, input logic ph, input logic s);
    beat_t b;
    b.data  = 16'(d);
    b.phase = ph;
    b.sat   = s;
    return b;
  endfunction

  // Reference quantizer: floor((lane + 2^30) / 2^31), clipped to 16 bits.
  function automatic beat_t model(input logic signed [63:0] lane, input logic ph);
    logic signed [64:0] v, q;
    beat_t b;
    v = lane;
    v = v + (65'sd1 <<< 30);
    q = v >>> 31;
    b.phase = ph;
    if (q > 65'sd32767) begin
      b.data = 16'sh7fff;
      b.sat  = 1'b1;
    end else if (q < -65'sd32768) begin
      b.data = 16'sh8000;
      b.sat  = 1'b1;
    end else begin
      b.data = q[15:0];
      b.sat  = 1'b0;
    end
    return b;
  endfunction

  function automatic logic signed [63:0] rand_lane();
    logic signed [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return r >>> 14;
    return r >>> 20;
  endfunction

  // Scoreboard and occupancy model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      occ_model = 0;
    end else begin
      check("occupancy", occupancy, occ_model);
      check("in_ready", in_ready, occ_model < DEPTH);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", out_valid, 1'b0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_data", out_data, $signed(mon_exp.data));
          check("sb_phase", out_phase, mon_exp.phase);
          check("sb_sat", out_sat, mon_exp.sat);
        end
        if (out_phase) occ_model--;
      end
      if (in_valid && in_ready) occ_model++;
    end
  end

  task automatic drive_pair(input logic signed [63:0] a, input logic signed [63:0] b,
                            input beat_t e1, input beat_t e2);
    in_data_1 = a;
    in_data_2 = b;
    in_valid  = 1'b1;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  task automatic send_pair(input logic signed [63:0] a, input logic signed [63:0] b,
                           input beat_t e1, input beat_t e2);
    logic accepted;
    drive_pair(a, b, e1, e2);
    accepted = 1'b0;
    for (int i = 0; i < 1000 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check("send_timeout", in_ready, 1'b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      cycle();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    occ_model = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    ready_cmd = 1'b0;
    rand_en   = 1'b0;
    rand_bit  = 1'b0;

    // Reset values.
    repeat (3) cycle();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_phase", out_phase, 1'b0);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_occupancy", occupancy, 0);
    reset = 1'b0;

    // Single pair: lane 1 the cycle after accept, lane 2 the next cycle.
    ready_cmd = 1'b1;
    send_pair(5 * ONE31, -3 * ONE31, mk(5, 1'b0, 1'b0), mk(-3, 1'b1, 1'b0));
    check("lat_l1_valid", out_valid, 1'b1);
    check("lat_l1_data", out_data, 5);
    check("lat_l1_phase", out_phase, 1'b0);
    cycle();
    check("lat_l2_valid", out_valid, 1'b1);
    check("lat_l2_data", out_data, -3);
    check("lat_l2_phase", out_phase, 1'b1);
    cycle();
    check("lat_idle_valid", out_valid, 1'b0);
    check("lat_idle_occ", occupancy, 0);

    // Rounding at and around the half-LSB point.
    send_pair(ONE30, -ONE30, mk(1, 1'b0, 1'b0), mk(0, 1'b1, 1'b0));
    send_pair(ONE30 - 1, -(ONE30 + 1), mk(0, 1'b0, 1'b0), mk(-1, 1'b1, 1'b0));
    wait_drain(50);

    // Saturation in both directions.
    send_pair(40000 * ONE31, -40000 * ONE31, mk(32767, 1'b0, 1'b1), mk(-32768, 1'b1, 1'b1));
    wait_drain(50);

    // Backpressure: four pairs absorbed, the fifth waits for a freed slot.
    ready_cmd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_pair((10 * i + 1) * ONE31, -(10 * i + 2) * ONE31,
                mk(10 * i + 1, 1'b0, 1'b0), mk(-(10 * i + 2), 1'b1, 1'b0));
    end
    drive_pair(77 * ONE31, -78 * ONE31, mk(77, 1'b0, 1'b0), mk(-78, 1'b1, 1'b0));
    check("bp_full_occ", occupancy, DEPTH);
    check("bp_full_ready", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("bp_hold_occ", occupancy, DEPTH);
      check("bp_hold_ready", in_ready, 1'b0);
      check("bp_hold_data", out_data, 1);
      check("bp_hold_phase", out_phase, 1'b0);
    end
    ready_cmd = 1'b1;
    cycle();
    check("bp_t1_phase", out_phase, 1'b1);
    check("bp_t1_ready", in_ready, 1'b0);
    cycle();
    check("bp_t2_occ", occupancy, DEPTH - 1);
    check("bp_t2_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("bp_t3_occ", occupancy, DEPTH);
    check("bp_t3_ready", in_ready, 1'b0);
    wait_drain(100);

    // Reset mid-stream with three pairs buffered.
    ready_cmd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_pair((i + 100) * ONE31, (i + 200) * ONE31,
                mk(i + 100, 1'b0, 1'b0), mk(i + 200, 1'b1, 1'b0));
    end
    check("mid_occ", occupancy, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_occ", occupancy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ready_cmd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("mid_no_stale", out_valid, 1'b0);
    end

    // Streaming: continuous input, random downstream readiness.
    rand_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic signed [63:0] a, b;
      a = rand_lane();
      b = rand_lane();
      send_pair(a, b, model(a, 1'b0), model(b, 1'b1));
    end
    wait_drain(2000);
    rand_en = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
